// File: rtl/clock_pkg.sv
// Shared constants for the digital-clock timekeeping path.
// Mode encodings, field limits and field widths.
package clock_pkg;

    localparam int MODE_W = 2;
    localparam int HR_W   = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [MODE_W-1:0] MODE_RUN     = 2'd0;
    localparam logic [MODE_W-1:0] MODE_SET_HR  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_SET_MIN = 2'd2;

    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/tick_gen.sv
// Terminal-count prescaler: counts 0..DIV-1 and emits a registered
// one-cycle tick on the wrap edge; restart reloads zero without a tick.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic                   clk,
    input  logic                   RESETn,
    input  logic                   restart,
    output logic [$clog2(DIV)-1:0] count,
    output logic                   tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;

    always_comb begin
        count_d = count_q + CW'(1);
        tick_d  = 1'b0;
        if (restart) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
            tick_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge RESETn) begin
        if (RESETn) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// HH:MM:SS timekeeping with RUN/SET_HR/SET_MIN button sequencing,
// a 1 Hz time base and a free-running display-scan strobe.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic              tick_1hz,
    output logic              tick_scan,
    output logic [MODE_W-1:0] mode,
    output logic [HR_W-1:0]   hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic              blink
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_HALF = TW'(TICK_DIV / 2);

    logic [TW-1:0]     cnt_1hz;
    logic              restart;
    logic              at_last;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [HR_W-1:0]   hr_q, hr_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic              blink_q, blink_d;

    tick_gen #(.DIV(TICK_DIV)) u_tick_1hz (
        .clk     (clk),
        .RESETn  (RESETn),
        .restart (restart),
        .count   (cnt_1hz),
        .tick    (tick_1hz)
    );

    tick_gen #(.DIV(SCAN_DIV)) u_tick_scan (
        .clk     (clk),
        .RESETn  (RESETn),
        .restart (1'b0),
        .count   (),
        .tick    (tick_scan)
    );

    // Same edge that raises tick_1hz also advances the time
    assign at_last = (cnt_1hz == T_LAST);

    always_comb begin
        mode_d  = mode_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        restart = 1'b0;
        unique case (mode_q)
            MODE_RUN: begin
                if (btn_mode) mode_d = MODE_SET_HR;
                if (at_last) begin
                    if (sec_q == SEC_MAX) begin
                        sec_d = '0;
                        if (min_q == MIN_MAX) begin
                            min_d = '0;
                            hr_d  = (hr_q == HR_MAX) ? '0 : hr_q + HR_W'(1);
                        end else begin
                            min_d = min_q + MIN_W'(1);
                        end
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end
            end
            MODE_SET_HR: begin
                if (btn_mode) begin
                    mode_d = MODE_SET_MIN;
                end else if (btn_inc) begin
                    hr_d = (hr_q == HR_MAX) ? '0 : hr_q + HR_W'(1);
                end
            end
            MODE_SET_MIN: begin
                if (btn_mode) begin
                    mode_d  = MODE_RUN;
                    sec_d   = '0;
                    restart = 1'b1;
                end else if (btn_inc) begin
                    min_d = (min_q == MIN_MAX) ? '0 : min_q + MIN_W'(1);
                end
            end
            default: mode_d = MODE_RUN;
        endcase
        blink_d = (mode_d != MODE_RUN) && (cnt_1hz < T_HALF);
    end

    always_ff @(posedge clk or posedge RESETn) begin
        if (RESETn) begin
            mode_q  <= MODE_RUN;
            hr_q    <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            blink_q <= blink_d;
        end
    end

    assign mode    = mode_q;
    assign hours   = hr_q;
    assign minutes = min_q;
    assign seconds = sec_q;
    assign blink   = blink_q;

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
Timekeeping controller for the digital-clock design. Contains its own prescalers running from the 50 MHz board clock. Generates a 1 Hz time-base strobe and a display-scan strobe. Sequences an HH:MM:SS counter through a RUN/SET state machine driven by two debounced button pulses. Sits between the button conditioning logic and the 7-segment display driver, which consumes hours/minutes/seconds, tick_scan and blink.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 Hz tick; must be even and >= 4.
SCAN_DIV, 50000, clk cycles per display-scan tick (1 kHz at 50 MHz); must be >= 2.

Ports:
clk  input  1  system clock, 50 MHz, all logic on rising edge
RESETn  input  1  asynchronous, active-high reset
btn_mode  input  1  single-cycle pulse, debounced upstream; advances mode
btn_inc  input  1  single-cycle pulse, debounced upstream; increments the field selected in set mode
tick_1hz  output  1  one-cycle strobe every TICK_DIV cycles
tick_scan  output  1  one-cycle strobe every SCAN_DIV cycles
mode  output  2  0=RUN, 1=SET_HR, 2=SET_MIN
hours  output  5  0..23
minutes  output  6  0..59
seconds  output  6  0..59
blink  output  1  field-blink enable for the display

Behaviour:
- Reset: on RESETn=1, immediately (async) set all outputs and internal counters to 0 and mode to RUN. Reset has priority over all events. Reset asserted mid-operation, including in set mode, behaves identically.
- Prescaler: count 0..TICK_DIV-1. In the cycle where count==TICK_DIV-1, the next edge loads count=0 and tick_1hz=1. tick_1hz is registered, high exactly 1 cycle. The first tick occurs TICK_DIV cycles after reset release.
- Scan prescaler: identical structure with SCAN_DIV. Free-running in all modes. Never restarted except by reset.
- All outputs are registered; no combinational path from inputs to outputs.
- RUN: on the same edge that raises tick_1hz, advance seconds. Carry rules: 59->0 with minutes+1; minutes 59->0 with hours+1; hours 23->0. 23:59:59 -> 00:00:00 in a single edge. New time and tick_1hz are visible in the same cycle.
- SET_HR: time does not advance; the prescaler keeps running and tick_1hz still pulses. btn_inc increments hours 0..23, wrapping 23->0, with no other field affected.
- SET_MIN: btn_inc increments minutes 0..59, wrapping 59->0. No carry into hours.
- Transitions on btn_mode: RUN->SET_HR->SET_MIN->RUN.
- Leaving SET_MIN for RUN: seconds=0 and 1 Hz prescaler count=0 on that edge. The first tick after exit occurs exactly TICK_DIV cycles later.
- Simultaneous btn_mode and btn_inc: mode change wins; btn_inc is dropped.
- btn_inc in RUN is ignored.
- blink: 0 in RUN. In set modes, blink=1 while prescaler count < TICK_DIV/2, else 0, giving a 1 Hz, 50% duty cycle. Registered.
- Counter widths: the 1 Hz prescaler is sized with $clog2(TICK_DIV) and the scan prescaler with $clog2(SCAN_DIV). No overflow beyond the terminal count.

Decomposition:
- Package clock_pkg holds:
  - mode encoding constants MODE_RUN=0, MODE_SET_HR=1, MODE_SET_MIN=2
  - limits HR_MAX=23, MIN_MAX=59, SEC_MAX=59
  - field widths
- Sub-module tick_gen (parameter DIV; ports clk, RESETn, restart, count, tick) provides a terminal-count prescaler. It is instantiated twice: the 1 Hz instance uses restart on SET_MIN->RUN, and the scan instance has restart tied to 0.
- The FSM and time counters stay in clock_time_ctrl.

Test Plan:
(All scenarios use TICK_DIV=10, SCAN_DIV=4.)
1. Reset then release, no buttons -> tick_1hz first high 10 cycles after release, then every 10 cycles. tick_scan every 4 cycles. After 3 ticks, time reads 00:00:03 and mode=0.
2. Enter SET_HR, pulse btn_inc 23 times, btn_mode, then btn_inc 59 times, btn_mode -> exits at 23:59:00 in RUN. After 60 ticks, reads 00:00:00 on the 60th tick edge.
3. In SET_HR with 30 cycles elapsed -> seconds frozen and blink toggles every 5 cycles. btn_inc at hours=23 -> 0. In SET_MIN, btn_inc at minutes=59 -> 0 with hours unchanged.
4. RUN at 05:06:07, btn_mode and btn_inc asserted in the same cycle -> mode=1, hours stays 5.
5. Exit SET_MIN when prescaler count=7 -> seconds=0, and the next tick_1hz comes exactly 10 cycles after the exit edge, not 3.
6. Assert RESETn mid-cycle while at 12:34:56 in SET_MIN -> all outputs 0 and mode=0 without waiting for a clk edge. Normal ticking resumes 10 cycles after release.
